// File: rtl/hub75_pkg.sv
// hub75_pkg: scan-engine state encoding and counter width helpers for hub75_scan_driver.
package hub75_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY} state_t;
  function automatic int col_w(int cols);
    return cols > 1 ? $clog2(cols) : 1;
  endfunction
  function automatic int row_w(int addr_w);
    return addr_w > 0 ? addr_w : 1;
  endfunction
  function automatic int plane_w(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int dur_w(int base_on, int depth, int clk_div, int lat_cyc);
    int m;
    m = base_on << (depth - 1);
    m = clk_div > m ? clk_div : m;
    m = lat_cyc > m ? lat_cyc : m;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/hub75_timer.sv
// hub75_timer: loadable down-counter; done marks the last cycle of the loaded interval.
module hub75_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 scan engine shifting two half-panel rows per line from a framebuffer.
// Define HUB75_BCM_EN to show every bit-plane with binary-weighted on-time; otherwise only the MSB plane.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int COLS    = 64,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter int LAT_CYC = 2,
  parameter int BASE_ON = 64
) (
  input  logic                           CLOCK_50,
  input  logic                           rst_n,
  input  logic                           enable,
  output logic                           pix_rd,
  output logic [ADDR_W+$clog2(COLS)-1:0] pix_addr,
  input  logic [3*DEPTH-1:0]             pix_rgb1,
  input  logic [3*DEPTH-1:0]             pix_rgb2,
  output logic [2:0]                     hub_rgb1,
  output logic [2:0]                     hub_rgb2,
  output logic                           hub_clk,
  output logic                           hub_lat,
  output logic                           hub_oe_n,
  output logic [ADDR_W-1:0]              hub_addr,
  output logic                           frame_start
);
  localparam int CW = col_w(COLS);
  localparam int RW = row_w(ADDR_W);
  localparam int PW = plane_w(DEPTH);
  localparam int DW = dur_w(BASE_ON, DEPTH, CLK_DIV, LAT_CYC);
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row, row_nxt;
  logic [PW-1:0] plane;
  logic [DW-1:0] dur;
  logic [2:0][DEPTH-1:0] ch1, ch2;
  logic last_plane, last_col, done;
`ifdef HUB75_BCM_EN
  assign last_plane = plane == PW'(DEPTH - 1);
`else
  assign plane = PW'(DEPTH - 1);
  assign last_plane = 1'b1;
`endif
  assign last_col = col == CW'(COLS - 1);
  assign row_nxt = last_plane ? row + 1'b1 : row;
  assign ch1 = pix_rgb1;
  assign ch2 = pix_rgb2;
  // Timer holds the length of the state being entered; it reloads on every done, i.e. every transition.
  assign dur = (state == LOAD || state == SHIFT_LO) ? DW'(CLK_DIV - 1)
             : (state == SHIFT_HI && last_col) ? DW'(1)
             : state == BLANK ? DW'(LAT_CYC - 1)
             : state == LATCH ? DW'((BASE_ON << plane) - 1) : '0;
  hub75_timer #(.W(DW)) u_timer (
    .clk(CLOCK_50),
    .rst_n,
    .load(done),
    .value(dur),
    .done
  );
  always_ff @(posedge CLOCK_50)
    if (!rst_n) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
`ifdef HUB75_BCM_EN
      plane <= '0;
`endif
      pix_rd <= 1'b0;
      pix_addr <= '0;
      hub_rgb1 <= '0;
      hub_rgb2 <= '0;
      hub_clk <= 1'b0;
      hub_lat <= 1'b0;
      hub_oe_n <= 1'b1;
      hub_addr <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_rd <= 1'b0;
      frame_start <= 1'b0;
      if (done) case (state)
        IDLE: if (enable) begin
          state <= FETCH;
          col <= '0;
          row <= '0;
`ifdef HUB75_BCM_EN
          plane <= '0;
`endif
          pix_rd <= 1'b1;
          pix_addr <= '0;
          frame_start <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state <= SHIFT_LO;
          hub_rgb1 <= {ch1[2][plane], ch1[1][plane], ch1[0][plane]};
          hub_rgb2 <= {ch2[2][plane], ch2[1][plane], ch2[0][plane]};
        end
        SHIFT_LO: begin
          state <= SHIFT_HI;
          hub_clk <= 1'b1;
        end
        SHIFT_HI: begin
          hub_clk <= 1'b0;
          if (last_col) begin
            state <= BLANK;
            hub_addr <= row;
          end else begin
            state <= FETCH;
            col <= col + 1'b1;
            pix_rd <= 1'b1;
            pix_addr <= {row, col + 1'b1};
          end
        end
        BLANK: begin
          state <= LATCH;
          hub_lat <= 1'b1;
        end
        LATCH: begin
          state <= DISPLAY;
          hub_lat <= 1'b0;
          hub_oe_n <= 1'b0;
        end
        DISPLAY: begin
          hub_oe_n <= 1'b1;
          col <= '0;
          row <= row_nxt;
`ifdef HUB75_BCM_EN
          plane <= last_plane ? '0 : plane + 1'b1;
`endif
          if (enable) begin
            state <= FETCH;
            pix_rd <= 1'b1;
            pix_addr <= {row_nxt, CW'(0)};
            frame_start <= last_plane && row == '1;
          end else state <= IDLE;
        end
      endcase
    end
endmodule
